// File: rtl/fetch_fd_stage_pkg.sv
// Shared core constants: instruction width, nop encoding, decode field positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_fd_stage_pkg;

  localparam int OPC_W  = 5;
  localparam int INSN_W = 32;
  localparam int RD_HI  = 26;
  localparam int RS_HI  = 21;
  localparam int RT_HI  = 16;

  // All-zero word: opcode 0 with rd=rs=rt=$0, a legal architectural nop.
  localparam logic [INSN_W-1:0] NOP_INSN = 32'h0;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fsm_state_e;

  function automatic logic [OPC_W-1:0] insn_opcode(input logic [INSN_W-1:0] insn);
    return insn[INSN_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/fetch_fd_stage_pc_reg.sv
// Program counter: load a target, increment by one (modulo 2^ADDR_W) or hold.
// Latency: new value visible one posedge after the control inputs.
// Backpressure: hold whenever neither load nor inc is asserted; load beats inc.
module pc_reg #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: redirect target, sequential successor, or unchanged.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_pc;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  // PC register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_fd_stage.sv
// Fetch stage and F/D latch: owns the PC, registers {ir, pc+1, valid} for decode.
// Latency: instruction at imem_addr appears on fd_ir one posedge later.
// Backpressure: stall holds PC and latch; redirect flushes and wins over stall.
module fetch_fd_stage
  import fetch_fd_stage_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INSN_W-1:0] imem_q,
  output logic [INSN_W-1:0] fd_ir,
  output logic [ADDR_W-1:0] fd_pc,
  output logic              fd_valid,
  output logic [CNT_W-1:0]  cnt_fetched,
  output logic [CNT_W-1:0]  cnt_bubbles
);

  fsm_state_e        state_q, state_d;
  logic [INSN_W-1:0] fd_ir_q, fd_ir_d;
  logic [ADDR_W-1:0] fd_pc_q, fd_pc_d;
  logic              fd_valid_q, fd_valid_d;
  logic [CNT_W-1:0]  cnt_fetched_q, cnt_fetched_d;
  logic [CNT_W-1:0]  cnt_bubbles_q, cnt_bubbles_d;
  logic [ADDR_W-1:0] pc;
  logic              pc_load;
  logic              pc_inc;

  pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clock  (clock),
    .reset_n(reset_n),
    .load   (pc_load),
    .load_pc(redirect_pc),
    .inc    (pc_inc),
    .pc     (pc)
  );

  // FSM next state, F/D latch update, PC control and perf counters.
  always_comb begin
    state_d       = state_q;
    fd_ir_d       = fd_ir_q;
    fd_pc_d       = fd_pc_q;
    fd_valid_d    = fd_valid_q;
    cnt_fetched_d = cnt_fetched_q;
    cnt_bubbles_d = cnt_bubbles_q;
    pc_load       = 1'b0;
    pc_inc        = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        // One idle cycle after reset: latch and PC untouched.
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect) begin
          // Whatever sits in F/D is on the wrong path, stalled or not.
          pc_load    = 1'b1;
          fd_ir_d    = NOP_INSN;
          fd_valid_d = 1'b0;
        end else if (!stall) begin
          pc_inc        = 1'b1;
          fd_ir_d       = imem_q;
          fd_pc_d       = pc + ADDR_W'(1);
          fd_valid_d    = 1'b1;
          cnt_fetched_d = cnt_fetched_q + CNT_W'(1);
        end
      end
      default: state_d = ST_BOOT;
    endcase

    // A bubble is counted for every cycle spent in RUN with an empty latch,
    // including the one left behind by the boot cycle.
    if (state_d == ST_RUN && !fd_valid_d) begin
      cnt_bubbles_d = cnt_bubbles_q + CNT_W'(1);
    end
  end

  // State, latch and counter registers; reset overrides stall and redirect.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= ST_BOOT;
      fd_ir_q       <= NOP_INSN;
      fd_pc_q       <= '0;
      fd_valid_q    <= 1'b0;
      cnt_fetched_q <= '0;
      cnt_bubbles_q <= '0;
    end else begin
      state_q       <= state_d;
      fd_ir_q       <= fd_ir_d;
      fd_pc_q       <= fd_pc_d;
      fd_valid_q    <= fd_valid_d;
      cnt_fetched_q <= cnt_fetched_d;
      cnt_bubbles_q <= cnt_bubbles_d;
    end
  end

  assign imem_addr   = pc;
  assign fd_ir       = fd_ir_q;
  assign fd_pc       = fd_pc_q;
  assign fd_valid    = fd_valid_q;
  assign cnt_fetched = cnt_fetched_q;
  assign cnt_bubbles = cnt_bubbles_q;

endmodule

// File: tb/tb_fetch_fd_stage.sv
// Bench for fetch_fd_stage: directed vector table, hand sequences, random run vs model.
// Latency: checks sampled 1 time unit after each posedge.
// Backpressure: stall/redirect driven directly by the bench.
module tb_fetch_fd_stage;

  localparam int AW = 12;
  localparam int DEPTH = 4096;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          stall;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_q;
  logic [31:0]   fd_ir;
  logic [AW-1:0] fd_pc;
  logic          fd_valid;
  logic [31:0]   cnt_fetched;
  logic [31:0]   cnt_bubbles;

  logic [31:0] imem [DEPTH];

  int n_total = 0;
  int n_pass  = 0;

  fetch_fd_stage #(.ADDR_W(AW), .RESET_PC('0), .CNT_W(32)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_q     (imem_q),
    .fd_ir      (fd_ir),
    .fd_pc      (fd_pc),
    .fd_valid   (fd_valid),
    .cnt_fetched(cnt_fetched),
    .cnt_bubbles(cnt_bubbles)
  );

  always #5 clock = ~clock;

  assign imem_q = imem[imem_addr];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic rd, input logic [AW-1:0] rp);
    reset_n     = r;
    stall       = s;
    redirect    = rd;
    redirect_pc = rp;
  endtask

  // Reference model: architectural view of fetch, not of the RTL's processes.
  int          m_pc, m_fdpc;
  logic [31:0] m_ir;
  bit          m_valid, m_live;
  int unsigned m_fetched, m_bubbles;

  task automatic model_step(input logic r, input logic s, input logic rd, input int rp);
    if (!r) begin
      m_pc = 0; m_ir = 32'h0; m_fdpc = 0; m_valid = 0;
      m_fetched = 0; m_bubbles = 0; m_live = 0;
    end else if (!m_live) begin
      m_live = 1;
      m_bubbles++;                       // empty latch in first live cycle
    end else if (rd) begin
      m_pc = rp; m_ir = 32'h0; m_valid = 0;
      m_bubbles++;
    end else if (s) begin
      if (!m_valid) m_bubbles++;
    end else begin
      m_ir = imem[m_pc];
      m_pc = (m_pc + 1) % DEPTH;
      m_fdpc = m_pc;
      m_valid = 1;
      m_fetched++;
    end
  endtask

  typedef struct {
    logic        rst_n, stl, rdr;
    logic [11:0] rpc;
    logic [31:0] e_ir;
    logic [11:0] e_fdpc;
    logic        e_valid;
    logic [11:0] e_pc;
    logic [31:0] e_fet, e_bub;
  } vec_t;

  vec_t vt [13];

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) imem[i] = 32'hC0DE_0000 | i;

    // ---------------- directed vector table ----------------
    //         rst stl rdr rpc     ir            fdpc    v  pc      fet bub
    vt[0]  = '{1'b0,1'b0,1'b0,12'h000, 32'h0,        12'h000,1'b0,12'h000, 0, 0};
    vt[1]  = '{1'b1,1'b0,1'b0,12'h000, 32'h0,        12'h000,1'b0,12'h000, 0, 1};
    vt[2]  = '{1'b1,1'b0,1'b0,12'h000, 32'hC0DE0000, 12'h001,1'b1,12'h001, 1, 1};
    vt[3]  = '{1'b1,1'b0,1'b0,12'h000, 32'hC0DE0001, 12'h002,1'b1,12'h002, 2, 1};
    vt[4]  = '{1'b1,1'b1,1'b0,12'h000, 32'hC0DE0001, 12'h002,1'b1,12'h002, 2, 1};
    vt[5]  = '{1'b1,1'b1,1'b0,12'h000, 32'hC0DE0001, 12'h002,1'b1,12'h002, 2, 1};
    vt[6]  = '{1'b1,1'b1,1'b0,12'h000, 32'hC0DE0001, 12'h002,1'b1,12'h002, 2, 1};
    vt[7]  = '{1'b1,1'b0,1'b0,12'h000, 32'hC0DE0002, 12'h003,1'b1,12'h003, 3, 1};
    vt[8]  = '{1'b1,1'b1,1'b1,12'h100, 32'h0,        12'h000,1'b0,12'h100, 3, 2};
    vt[9]  = '{1'b1,1'b0,1'b0,12'h000, 32'hC0DE0100, 12'h101,1'b1,12'h101, 4, 2};
    vt[10] = '{1'b1,1'b0,1'b1,12'hFFF, 32'h0,        12'h000,1'b0,12'hFFF, 4, 3};
    vt[11] = '{1'b1,1'b0,1'b0,12'h000, 32'hC0DE0FFF, 12'h000,1'b1,12'h000, 5, 3};
    vt[12] = '{1'b1,1'b0,1'b0,12'h000, 32'hC0DE0000, 12'h001,1'b1,12'h001, 6, 3};

    for (int i = 0; i < 13; i++) begin
      drive(vt[i].rst_n, vt[i].stl, vt[i].rdr, vt[i].rpc);
      tick();
      chk($sformatf("vec%0d fd_ir", i),    {32'h0, fd_ir},    {32'h0, vt[i].e_ir});
      chk($sformatf("vec%0d fd_valid", i), {63'h0, fd_valid}, {63'h0, vt[i].e_valid});
      chk($sformatf("vec%0d imem_addr", i),{52'h0, imem_addr},{52'h0, vt[i].e_pc});
      if (vt[i].e_valid)
        chk($sformatf("vec%0d fd_pc", i),  {52'h0, fd_pc},    {52'h0, vt[i].e_fdpc});
      if (!vt[i].rst_n)
        chk($sformatf("vec%0d fd_pc_rst", i), {52'h0, fd_pc}, 64'h0);
      chk($sformatf("vec%0d cnt_fetched", i), {32'h0, cnt_fetched}, {32'h0, vt[i].e_fet});
      chk($sformatf("vec%0d cnt_bubbles", i), {32'h0, cnt_bubbles}, {32'h0, vt[i].e_bub});
    end

    // ---------------- reset asserted mid-stall ----------------
    drive(1'b1, 1'b1, 1'b0, '0);
    tick();
    chk("midstall valid_before", {63'h0, fd_valid}, 64'h1);
    drive(1'b0, 1'b1, 1'b1, 12'h0AB);
    tick();
    chk("rst_midstall fd_ir",     {32'h0, fd_ir},       64'h0);
    chk("rst_midstall fd_pc",     {52'h0, fd_pc},       64'h0);
    chk("rst_midstall fd_valid",  {63'h0, fd_valid},    64'h0);
    chk("rst_midstall imem_addr", {52'h0, imem_addr},   64'h0);
    chk("rst_midstall fetched",   {32'h0, cnt_fetched}, 64'h0);
    chk("rst_midstall bubbles",   {32'h0, cnt_bubbles}, 64'h0);

    // ---------------- 10 fetches + 2 redirects ----------------
    drive(1'b1, 1'b0, 1'b0, '0);
    tick();                                   // boot cycle
    for (int k = 0; k < 5; k++) tick();
    drive(1'b1, 1'b0, 1'b1, 12'h200);
    tick();
    drive(1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 5; k++) tick();
    drive(1'b1, 1'b0, 1'b1, 12'h300);
    tick();
    chk("ten_fetch cnt_fetched", {32'h0, cnt_fetched}, 64'd10);
    chk("ten_fetch cnt_bubbles", {32'h0, cnt_bubbles}, 64'd3);
    chk("ten_fetch imem_addr",   {52'h0, imem_addr},   64'h300);

    // ---------------- randomized run against the model ----------------
    for (int i = 0; i < DEPTH; i++) imem[i] = $urandom;
    drive(1'b0, 1'b0, 1'b0, '0);
    model_step(1'b0, 1'b0, 1'b0, 0);
    tick();
    for (int c = 0; c < 3000; c++) begin
      logic r, s, rd;
      logic [AW-1:0] rp;
      r  = ($urandom_range(0, 199) != 0);
      s  = ($urandom_range(0, 9) < 3);
      rd = ($urandom_range(0, 9) == 0);
      rp = AW'($urandom);
      if ($urandom_range(0, 15) == 0) rp = 12'hFFF;   // exercise wrap often
      drive(r, s, rd, rp);
      model_step(r, s, rd, int'(rp));
      tick();
      chk("rnd fd_valid",  {63'h0, fd_valid},  {63'h0, m_valid});
      chk("rnd fd_ir",     {32'h0, fd_ir},     {32'h0, m_ir});
      chk("rnd imem_addr", {52'h0, imem_addr}, 64'(m_pc));
      if (m_valid) chk("rnd fd_pc", {52'h0, fd_pc}, 64'(m_fdpc));
      chk("rnd cnt_fetched", {32'h0, cnt_fetched}, 64'(m_fetched));
      chk("rnd cnt_bubbles", {32'h0, cnt_bubbles}, 64'(m_bubbles));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
